sa_cache_mem_ctrl: RTL and testbench

Memory-side controller that sits directly downstream of sa_cache. It consumes the cache's miss request and evictions, and produces the refill line plus the i_memory_response handshake the cache waits on. Evicted dirty words go into a small write-back FIFO. The FIFO drains to main memory over a single req/ack port when no refill is pending.

---
 rtl/sa_cache_mem_ctrl.sv | 165 ++++++++++++++++
 tb/tb_sa_cache_mem_ctrl.sv | 369 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sa_cache_mem_ctrl.sv
// sa_cache_mem_ctrl: refill and write-back controller below sa_cache.
// Optional macro WB_FWD_EN: refill forwarding from the write-back FIFO.
module sa_cache_mem_ctrl #(
  parameter int ADDR_W   = 32,
  parameter int DATA_W   = 32,
  parameter int WB_DEPTH = 4,
  parameter int LINE_LSB = 6
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cache_miss,
  input  logic [ADDR_W-1:0] miss_addr,
  input  logic              evict,
  input  logic [ADDR_W-1:0] evict_addr,
  input  logic [DATA_W-1:0] evict_data,
  output logic [DATA_W-1:0] o_memory_line,
  output logic              o_memory_response,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic              mem_ack,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              wb_full,
  output logic              wb_overflow,
  output logic              busy
);

  localparam int PW = $clog2(WB_DEPTH);
  localparam int CW = PW + 1;

  typedef enum logic [1:0] {
    IDLE,
    REFILL,
    DRAIN,
    RESP
  } state_t;

  state_t state;

  logic [ADDR_W-1:0] fa [WB_DEPTH];
  logic [DATA_W-1:0] fd [WB_DEPTH];
  logic [PW-1:0]     wr_ptr;
  logic [PW-1:0]     rd_ptr;
  logic [CW-1:0]     count;
  logic              push;
  logic              pop;
  logic              hit;
`ifdef WB_FWD_EN
  logic [DATA_W-1:0] hit_data;
`endif

  assign wb_full = (count == CW'(WB_DEPTH));
  assign push    = evict && !wb_full;
  assign pop     = (state == DRAIN) && mem_ack;
  assign busy    = (state != IDLE);

  // Line match of the miss against live entries, oldest to newest.
  always_comb begin
    logic [PW-1:0] idx;
    idx = '0;
    hit = 1'b0;
`ifdef WB_FWD_EN
    hit_data = '0;
`endif
    for (int k = 0; k < WB_DEPTH; k++) begin
      idx = rd_ptr + PW'(k);
      if (CW'(k) < count &&
          fa[idx][ADDR_W-1:LINE_LSB] ==
          miss_addr[ADDR_W-1:LINE_LSB]) begin
        hit = 1'b1;
`ifdef WB_FWD_EN
        hit_data = fd[idx];
`endif
      end
    end
  end

  // FIFO storage; contents only matter below count.
  always_ff @(posedge clk) begin
    if (push) begin
      fa[wr_ptr] <= evict_addr;
      fd[wr_ptr] <= evict_data;
    end
  end

  // FIFO pointers, occupancy and sticky overflow.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      count       <= '0;
      wb_overflow <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop) rd_ptr <= rd_ptr + 1'b1;
      if (evict && wb_full) wb_overflow <= 1'b1;
      unique case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: ;
      endcase
    end
  end

  // Control FSM; all memory and cache outputs are registered here.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state             <= IDLE;
      mem_req           <= 1'b0;
      mem_we            <= 1'b0;
      mem_addr          <= '0;
      mem_wdata         <= '0;
      o_memory_line     <= '0;
      o_memory_response <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (cache_miss && !hit) begin
            state    <= REFILL;
            mem_req  <= 1'b1;
            mem_we   <= 1'b0;
            mem_addr <= miss_addr;
          end
`ifdef WB_FWD_EN
          else if (cache_miss) begin
            state             <= RESP;
            o_memory_line     <= hit_data;
            o_memory_response <= 1'b1;
          end
`endif
          else if (count != '0) begin
            // a conflicting miss also lands here: drain first
            state     <= DRAIN;
            mem_req   <= 1'b1;
            mem_we    <= 1'b1;
            mem_addr  <= fa[rd_ptr];
            mem_wdata <= fd[rd_ptr];
          end
        end
        REFILL: begin
          if (mem_ack) begin
            state             <= RESP;
            mem_req           <= 1'b0;
            o_memory_line     <= mem_rdata;
            o_memory_response <= 1'b1;
          end
        end
        DRAIN: begin
          if (mem_ack) begin
            state   <= IDLE;
            mem_req <= 1'b0;
            mem_we  <= 1'b0;
          end
        end
        RESP: begin
          state             <= IDLE;
          o_memory_response <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_sa_cache_mem_ctrl.sv
// tb_sa_cache_mem_ctrl: scoreboard bench for sa_cache_mem_ctrl.
// Honours WB_FWD_EN the same way the design does.
module tb_sa_cache_mem_ctrl;

  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        cache_miss = 1'b0;
  logic [31:0] miss_addr = '0;
  logic        evict = 1'b0;
  logic [31:0] evict_addr = '0;
  logic [31:0] evict_data = '0;
  logic [31:0] o_memory_line;
  logic        o_memory_response;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic        mem_ack = 1'b0;
  logic [31:0] mem_rdata = '0;
  logic        wb_full;
  logic        wb_overflow;
  logic        busy;

  sa_cache_mem_ctrl dut (
    .clk(clk), .rst(rst),
    .cache_miss(cache_miss), .miss_addr(miss_addr),
    .evict(evict), .evict_addr(evict_addr), .evict_data(evict_data),
    .o_memory_line(o_memory_line), .o_memory_response(o_memory_response),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_ack(mem_ack), .mem_rdata(mem_rdata),
    .wb_full(wb_full), .wb_overflow(wb_overflow), .busy(busy)
  );

  always #5 clk = ~clk;

  typedef struct { logic [31:0] a; logic [31:0] d; } wb_t;

  int          compared = 0;
  int          mismatched = 0;
  wb_t         wq[$];
  logic [31:0] respq[$];
  logic [31:0] store [bit [25:0]];
  logic [31:0] mem_img [bit [25:0]];
  int          cnt = 0;
  bit          ovf = 1'b0;
  bit          miss_active = 1'b0;
  logic [31:0] cur_miss = '0;
  int          reads = 0;
  int          writes = 0;
  int          resps = 0;
  int          ack_mode = 0;

  function automatic void check(input string name,
                                input logic [31:0] act,
                                input logic [31:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endfunction

  function automatic void fail_now(input string name);
    compared++;
    mismatched++;
    $display("FAIL %s: got event/timeout expected none", name);
  endfunction

  function automatic bit [25:0] line(input logic [31:0] a);
    return a[31:6];
  endfunction

  function automatic logic [31:0] defv(input bit [25:0] l);
    return {6'h2B, l} ^ 32'h5A5A_0F0F;
  endfunction

  function automatic logic [31:0] ref_line(input logic [31:0] a);
    return store.exists(line(a)) ? store[line(a)] : defv(line(a));
  endfunction

  function automatic logic [31:0] mem_val(input logic [31:0] a);
    return mem_img.exists(line(a)) ? mem_img[line(a)] : defv(line(a));
  endfunction

  function automatic bit pending(input bit [25:0] l);
    foreach (wq[i]) if (line(wq[i].a) == l) return 1'b1;
    return 1'b0;
  endfunction

  // One clock: occupancy checks, then memory responder drive.
  task automatic step();
    @(posedge clk);
    #1;
    if (rst) begin
      check("wb_full", {31'b0, wb_full}, {31'b0, cnt == DEPTH});
      check("wb_overflow", {31'b0, wb_overflow}, {31'b0, ovf});
    end
    evict = 1'b0;
    case (ack_mode)
      0:       mem_ack = 1'b0;
      1:       mem_ack = 1'b1;
      default: mem_ack = ($urandom_range(0, 2) == 0);
    endcase
    mem_rdata = (mem_req && !mem_we) ? mem_val(mem_addr) : $urandom;
  endtask

  task automatic do_evict(input logic [31:0] a, input logic [31:0] d);
    evict = 1'b1;
    evict_addr = a;
    evict_data = d;
    if (cnt < DEPTH) begin
      wq.push_back('{a: a, d: d});
      cnt++;
      store[line(a)] = d;
    end else begin
      ovf = 1'b1;
    end
  endtask

  task automatic issue_miss(input logic [31:0] a);
    cache_miss = 1'b1;
    miss_addr = a;
    cur_miss = a;
    miss_active = 1'b1;
    respq.push_back(ref_line(a));
  endtask

  task automatic wait_resp(input int budget, output int lat);
    lat = 0;
    do begin
      step();
      lat++;
    end while (!o_memory_response && lat < budget);
    if (!o_memory_response) fail_now("resp_timeout");
    cache_miss = 1'b0;
    miss_active = 1'b0;
  endtask

  task automatic wait_drained(input int budget);
    for (int i = 0; i < budget; i++) begin
      if (cnt == 0 && !busy) break;
      step();
    end
    check("drain_done", cnt, 0);
  endtask

  // Monitor: pops expectations whenever the DUT completes an op.
  logic        p_req = 1'b0;
  logic        p_ack = 1'b0;
  logic        p_we = 1'b0;
  logic [31:0] p_addr = '0;
  logic [31:0] p_wdata = '0;

  always @(negedge clk) begin
    if (!rst) begin
      p_req = 1'b0;
      p_ack = 1'b0;
    end else begin
      if (p_req && p_ack) begin
        check("req_drop", {31'b0, mem_req}, 32'd0);
      end else if (p_req && mem_req) begin
        check("hold_we", {31'b0, mem_we}, {31'b0, p_we});
        check("hold_addr", mem_addr, p_addr);
        check("hold_wdata", mem_wdata, p_wdata);
      end
      if (mem_req && mem_ack) begin
        if (mem_we) begin
          if (wq.size() == 0) begin
            fail_now("unexpected_write");
          end else begin
            wb_t e;
            e = wq.pop_front();
            cnt--;
            check("wr_addr", mem_addr, e.a);
            check("wr_data", mem_wdata, e.d);
          end
          mem_img[line(mem_addr)] = mem_wdata;
          writes++;
        end else begin
          check("rd_miss_active", {31'b0, miss_active}, 32'd1);
          check("rd_addr", mem_addr, cur_miss);
          check("rd_no_pending", {31'b0, pending(line(mem_addr))}, 32'd0);
          reads++;
        end
      end
      if (o_memory_response) begin
        resps++;
        if (respq.size() == 0) fail_now("resp_unexpected");
        else check("resp_line", o_memory_line, respq.pop_front());
      end
      p_req = mem_req;
      p_ack = mem_ack;
      p_we = mem_we;
      p_addr = mem_addr;
      p_wdata = mem_wdata;
    end
  end

  initial begin
    int lat;
    int r0;
    int w0;
    int s0;
    logic [31:0] a;

    repeat (3) @(posedge clk);
    #1;
    check("rst_req", {31'b0, mem_req}, 32'd0);
    check("rst_we", {31'b0, mem_we}, 32'd0);
    check("rst_addr", mem_addr, 32'd0);
    check("rst_wdata", mem_wdata, 32'd0);
    check("rst_line", o_memory_line, 32'd0);
    check("rst_resp", {31'b0, o_memory_response}, 32'd0);
    check("rst_busy", {31'b0, busy}, 32'd0);
    check("rst_full", {31'b0, wb_full}, 32'd0);
    check("rst_ovf", {31'b0, wb_overflow}, 32'd0);
    rst = 1'b1;
    step();

    // Simple miss with zero memory wait.
    ack_mode = 1;
    mem_img[line(32'h1240)] = 32'hDEAD_BEEF;
    store[line(32'h1240)] = 32'hDEAD_BEEF;
    r0 = reads;
    s0 = resps;
    issue_miss(32'h0000_1240);
    wait_resp(20, lat);
    check("miss_latency", lat, 2);
    repeat (4) step();
    check("miss_reads", reads - r0, 1);
    check("miss_resps", resps - s0, 1);

    // Drain three entries in order.
    ack_mode = 0;
    w0 = writes;
    for (int i = 1; i <= 3; i++) begin
      do_evict(32'h100 * i, i);
      step();
    end
    ack_mode = 2;
    wait_drained(200);
    check("drain_writes", writes - w0, 3);

    // Fill past capacity with memory stalled.
    ack_mode = 0;
    for (int i = 0; i < 5; i++) begin
      do_evict(32'h3000 + 32'h40 * i, 32'h0F00 + i);
      step();
    end
    check("ovf_set", {31'b0, wb_overflow}, 32'd1);
    ack_mode = 2;
    wait_drained(200);
    step();
    check("ovf_sticky", {31'b0, wb_overflow}, 32'd1);

    // Miss raised in a drain ack cycle beats the queued writes.
    ack_mode = 0;
    for (int i = 0; i < 3; i++) begin
      do_evict(32'h2000 + 32'h40 * i, 32'h2200 + i);
      step();
    end
    for (int i = 0; i < 20 && !(mem_req && mem_we); i++) step();
    mem_ack = 1'b1;
    issue_miss(32'h0000_4000);
    step();
    step();
    check("prio_req", {31'b0, mem_req}, 32'd1);
    check("prio_we", {31'b0, mem_we}, 32'd0);
    check("prio_addr", mem_addr, 32'h4000);
    ack_mode = 2;
    wait_resp(200, lat);
    wait_drained(200);

    // Conflict: miss on a line still sitting in the FIFO.
    ack_mode = 0;
    issue_miss(32'h0000_8000);
    step();
    step();
    do_evict(32'h0000_0840, 32'hA5A5_A5A5);
    step();
    mem_ack = 1'b1;
    step();
    check("conf_resp1", {31'b0, o_memory_response}, 32'd1);
    miss_active = 1'b0;
    r0 = reads;
    w0 = writes;
    issue_miss(32'h0000_0844);
    step();
    step();
`ifdef WB_FWD_EN
    check("fwd_resp", {31'b0, o_memory_response}, 32'd1);
    cache_miss = 1'b0;
    miss_active = 1'b0;
    repeat (3) step();
    check("fwd_no_read", reads - r0, 0);
    ack_mode = 2;
    wait_drained(200);
    check("fwd_drain_write", writes - w0, 1);
`else
    check("conf_drain_we", {31'b0, mem_req && mem_we}, 32'd1);
    check("conf_drain_addr", mem_addr, 32'h840);
    ack_mode = 2;
    wait_resp(400, lat);
    check("conf_writes", writes - w0, 1);
    check("conf_reads", reads - r0, 1);
    wait_drained(200);
`endif

    // Reset in the middle of a refill with the FIFO full.
    ack_mode = 0;
    issue_miss(32'h0000_9000);
    step();
    step();
    for (int i = 0; i < 4; i++) begin
      do_evict(32'hA000 + 32'h40 * i, 32'hA0 + i);
      step();
    end
    check("pre_rst_full", {31'b0, wb_full}, 32'd1);
    check("pre_rst_refill", {31'b0, mem_req && !mem_we}, 32'd1);
    #2 rst = 1'b0;
    #1;
    check("arst_req", {31'b0, mem_req}, 32'd0);
    check("arst_resp", {31'b0, o_memory_response}, 32'd0);
    check("arst_busy", {31'b0, busy}, 32'd0);
    check("arst_full", {31'b0, wb_full}, 32'd0);
    wq.delete();
    respq.delete();
    cnt = 0;
    ovf = 1'b0;
    miss_active = 1'b0;
    cache_miss = 1'b0;
    mem_ack = 1'b0;
    @(posedge clk);
    #1 rst = 1'b1;
    ack_mode = 1;
    for (int i = 0; i < 8; i++) begin
      step();
      check("post_rst_idle", {31'b0, mem_req}, 32'd0);
    end

    // Random traffic over a small set of lines.
    ack_mode = 2;
    for (int n = 0; n < 300; n++) begin
      int r;
      r = $urandom_range(0, 9);
      a = 32'h0001_0000 + {$urandom_range(0, 7), 6'b0};
      if (r < 4) begin
        do_evict(a, $urandom);
        step();
      end else if (r < 6) begin
        issue_miss(a | {26'b0, 6'($urandom_range(0, 63))});
        wait_resp(400, lat);
      end else begin
        step();
      end
    end
    wait_drained(400);
    repeat (4) step();
    check("resp_all_seen", respq.size(), 0);
    check("writes_all_seen", wq.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             compared, mismatched);
    $finish;
  end

endmodule
